// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam int unsigned PORT_CPU        = 0;
    localparam int unsigned PORT_DBG        = 1;
    localparam int unsigned MAX_WAIT_CYCLES = 15;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes plus the memory pin bundle.
// slave  = arbiter side; master = requesters and memory side.
interface mem_arbiter_if;

    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [31:0] adr0;
    logic [31:0] adr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        done0;
    logic        done1;
    logic [31:0] rdata;
    logic        err;
    logic        mem_memwrite;
    logic [31:0] mem_adr;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    modport slave (
        input  req0, req1, we0, we1, adr0, adr1, wdata0, wdata1, mem_readdata,
        output done0, done1, rdata, err, mem_memwrite, mem_adr, mem_writedata
    );

    modport master (
        output req0, req1, we0, we1, adr0, adr1, wdata0, wdata1, mem_readdata,
        input  done0, done1, rdata, err, mem_memwrite, mem_adr, mem_writedata
    );

endinterface

// File: rtl/mem_arbiter_rr2.sv
// arb_rr2: two-input round-robin picker; on a tie the port not granted last wins.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] grant
);

    // One-hot grant: single requester wins outright, tie goes away from last owner.
    always_comb begin
        grant = '0;
        if (req0 && req1) begin
            grant = (last == 1'(PORT_DBG)) ? 2'b01 : 2'b10;
        end else begin
            grant = {req1, req0};
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the single-port memory to the core (port 0) or the
// loader/debug port (port 1), holds the access WAIT_CYCLES extra cycles and
// returns registered read data with a one-cycle done pulse.
// Optional feature macro: MEM_ARB_ALIGN_CHECK_EN (misaligned accesses flag err,
// suppress the write strobe and return zero data).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int unsigned CW = (WAIT_CYCLES == 0) ? 1 : $clog2(WAIT_CYCLES + 1);

    if (WAIT_CYCLES > MAX_WAIT_CYCLES) begin : g_cfg_err
        $error("mem_arbiter: WAIT_CYCLES out of range");
    end

    state_t          state;
    state_t          state_nx;
    logic [1:0]      grant;
    logic            sel;
    logic            last;
    logic            owner;
    logic            we_q;
    logic            bad_q;
    logic            align_bad;
    logic [31:0]     adr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic [31:0]     sel_adr;
    logic [CW-1:0]   cnt;

    arb_rr2 u_rr (
        .req0  (bus.req0),
        .req1  (bus.req1),
        .last  (last),
        .grant (grant)
    );

    assign sel     = grant[1];
    assign sel_adr = sel ? bus.adr1 : bus.adr0;

`ifdef MEM_ARB_ALIGN_CHECK_EN
    assign align_bad = |sel_adr[1:0];
`else
    assign align_bad = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: grant from IDLE, count down in ACCESS, single RESP cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|grant) state_nx = ACCESS;
            ACCESS:  if (cnt == '0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Grant-time latches, wait counter and read-data capture on the final ACCESS cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last    <= 1'(PORT_DBG);
            owner   <= 1'(PORT_CPU);
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            if (state == IDLE && |grant) begin
                last    <= sel;
                owner   <= sel;
                we_q    <= sel ? bus.we1 : bus.we0;
                adr_q   <= sel_adr;
                wdata_q <= sel ? bus.wdata1 : bus.wdata0;
                bad_q   <= align_bad;
                cnt     <= CW'(WAIT_CYCLES);
            end
            if (state == ACCESS) begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    rdata_q <= bad_q ? '0 : bus.mem_readdata;
                end
            end
        end
    end

    assign bus.mem_adr       = adr_q;
    assign bus.mem_writedata = wdata_q;
    assign bus.mem_memwrite  = (state == ACCESS) && (cnt == '0) && we_q && !bad_q;
    assign bus.rdata         = rdata_q;
    assign bus.done0         = (state == RESP) && (owner == 1'(PORT_CPU));
    assign bus.done1         = (state == RESP) && (owner == 1'(PORT_DBG));

`ifdef MEM_ARB_ALIGN_CHECK_EN
    assign bus.err = (state == RESP) && bad_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule
